mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter peripheral. It is a bus responder on the processor's MEM-stage data bus, the same addr/data_in/write_en/mem_read signals the data memory sees. Stores to its TXDATA word push bytes into an internal FIFO, and an 8N1 serial FSM drains the FIFO onto a single tx pin. Its read data is OR-ed into the memory unit's read-data path at top level.

Parameters:
ADDR_WIDTH, 10, width of the data-bus address; matches the processor.
BASE_ADDR, 10'h3F0, word-aligned base of the 2-word register window.
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200).
FIFO_DEPTH, 8, TX byte FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
addr  input  ADDR_WIDTH  byte address from the EX/MEM result; addr[1:0] ignored
data_in  input  32  store data
write_en  input  1  store strobe, sampled at the rising edge
mem_read  input  1  load strobe, qualifies data_out
data_out  output  32  combinational read data; 0 when not selected
tx  output  1  serial line, registered, idle high
tx_busy  output  1  high while the FIFO is non-empty or the FSM is not IDLE

Behaviour:
- Register map:
  - TXDATA = BASE_ADDR+0. Write pushes data_in[7:0]. Reads return 0.
  - STATUS = BASE_ADDR+4. Read bits: [0] full, [1] empty, [2] fsm_active, [3] overflow, [7:4] fifo count (saturating at 15), others 0. Writing with data_in[3]=1 clears overflow; other written bits are ignored.
- Select: sel = (addr[ADDR_WIDTH-1:3] == BASE_ADDR[ADDR_WIDTH-1:3]).
- data_out = register value only when mem_read & sel; otherwise 32'h0. It is purely combinational so the MEM-stage forward sees it in the same cycle.
- Reset: tx=1, FSM=IDLE, FIFO empty, count=0, overflow=0, shifter=0, baud counter=0. data_out follows the rule above. tx_busy=0.
- FIFO rules:
  - Push when write_en & sel & TXDATA & not full.
  - Push while full: byte dropped, overflow set (sticky).
  - Simultaneous push and pop when full: both happen, count unchanged, no overflow.
  - Simultaneous push and pop when empty is impossible, because a pop requires non-empty.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty: pop, load shifter, baud_cnt=0, go START, tx<=0 at the same edge.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then tx<=shifter[0], bit_idx=0, go DATA.
  - DATA: each CLKS_PER_BIT cycles, shift right and drive the next bit, LSB first. After bit 7's period, tx<=1 and go STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles, then go IDLE.
- Latency:
  - A TXDATA write sampled at edge E into an empty FIFO with the FSM idle makes tx fall at edge E+1.
  - A frame is 10*CLKS_PER_BIT cycles.
  - Back-to-back bytes: the stop bit lasts CLKS_PER_BIT+1 cycles, because of one IDLE cycle before the next pop.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Reset mid-frame: the frame is abandoned, tx=1 at the next edge, and FIFO contents are discarded.
- A write to STATUS never touches the FIFO. A write outside the window is ignored.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, STOP);
  - the register offsets TXDATA_OFS=0 and STATUS_OFS=4;
  - the STATUS bit index constants.
- Sub-module sync_fifo holds the FIFO.
  - Parameters: WIDTH=8, DEPTH.
  - Ports: clk, rst, push, pop, wdata, rdata, full, empty, count.
  - Read data is first-word-fall-through.
- The top level holds address decode, the overflow flag, and the TX FSM.

Test Plan:
Use CLKS_PER_BIT=4, FIFO_DEPTH=8, BASE_ADDR=10'h3F0 for simulation.
1. Assert rst for 2 cycles, then read STATUS (addr 3F4, mem_read=1) -> tx=1, tx_busy=0, data_out=32'h00000002.
2. Write 32'hFFFF_FFA5 to 3F0 at edge E -> tx=0 for cycles E+1..E+4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then tx=1. tx_busy falls after 40 cycles.
3. Write bytes 01..0A to 3F0 on 10 consecutive edges -> bytes 01..09 transmitted in order, 0A dropped. A STATUS read right after the 10th write returns overflow=1 and count=8.
4. Continue from scenario 3: write 32'h8 to 3F4 -> a STATUS read shows overflow=0. FIFO count is unchanged by the write.
5. Assert rst during DATA bit 3 of a frame with 2 bytes queued -> tx=1 at the next edge, STATUS=32'h2, and no further tx transitions for 100 cycles.
6. Read 3F0 with mem_read=1, read 3F4 with mem_read=0, and read 3E0 with mem_read=1 -> data_out=0 in all three cases.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the MMIO UART transmitter.
// The STATUS bit indices are the software-visible layout of the STATUS word.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [2:0] TXDATA_OFS = 3'd0;
    localparam logic [2:0] STATUS_OFS = 3'd4;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_ACTIVE  = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_MSB = 7;

    function automatic logic [3:0] sat_cnt4(input int unsigned v);
        return (v > 32'd15) ? 4'hF : v[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push while full succeeds only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             rd_ok;
    logic             wr_ok;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign count = cnt_q;
    assign rdata = mem_q[rptr_q];

    assign rd_ok = pop & ~empty;
    assign wr_ok = push & (~full | rd_ok);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (rd_ok) begin
                rptr_q <= rptr_q + AW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MEM-stage data bus.
// TXDATA stores feed a byte FIFO; a serial FSM drains it onto tx.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 10'h3F0,
    parameter int                    CLKS_PER_BIT = 434,
    parameter int                    FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           data_in,
    input  logic                  write_en,
    input  logic                  mem_read,
    output logic [31:0]           data_out,
    output logic                  tx,
    output logic                  tx_busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state_q;
    logic          tx_q;
    logic [7:0]    shifter_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic          overflow_q;

    logic          sel;
    logic          wr_tx;
    logic          wr_st;
    logic          rd_st;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic          baud_last;
    logic [31:0]   status;
    logic          unused_bits;

    assign sel   = (addr[ADDR_WIDTH-1:3] == BASE_ADDR[ADDR_WIDTH-1:3]);
    assign wr_tx = write_en & sel & (addr[2] == TXDATA_OFS[2]);
    assign wr_st = write_en & sel & (addr[2] == STATUS_OFS[2]);
    assign rd_st = mem_read & sel & (addr[2] == STATUS_OFS[2]);

    assign unused_bits = ^{addr[1:0], data_in[31:8]};

    // The FSM only consumes a byte from IDLE, so pop never meets an empty FIFO.
    assign fifo_pop  = (state_q == IDLE) & ~fifo_empty;
    assign baud_last = (baud_q == BAUD_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_tx),
        .pop   (fifo_pop),
        .wdata (data_in[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        status                         = '0;
        status[ST_FULL]                = fifo_full;
        status[ST_EMPTY]               = fifo_empty;
        status[ST_ACTIVE]              = (state_q != IDLE);
        status[ST_OVF]                 = overflow_q;
        status[ST_CNT_MSB:ST_CNT_LSB]  = sat_cnt4(32'(fifo_cnt));
    end

    assign data_out = rd_st ? status : 32'h0;
    assign tx       = tx_q;
    assign tx_busy  = ~fifo_empty | (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (wr_tx & fifo_full & ~fifo_pop) begin
            overflow_q <= 1'b1;
        end else if (wr_st & data_in[3]) begin
            overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            shifter_q <= '0;
            baud_q    <= '0;
            bit_idx_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shifter_q <= fifo_rdata;
                        baud_q    <= '0;
                        tx_q      <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        tx_q      <= shifter_q[0];
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shifter_q <= shifter_q >> 1;
                            tx_q      <= shifter_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
